ram_hs: RTL and testbench

RAM_HS -- requirements
Module: ram_hs

---
 rtl/ram_pkg.sv | 9 +
 rtl/ram_hs_if.sv | 29 ++
 rtl/ram_resp_fifo.sv | 55 +++++
 rtl/ram_hs.sv | 84 ++++++++
 tb/tb_ram_hs.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants for the handshaked RAM slice.
//   RESP_DEPTH      entries in the read response buffer
//   DEFAULT_DATA_W  default word width (bits, multiple of 8)
//   DEFAULT_ADDR_W  default word address width
package ram_pkg;
  localparam int unsigned RESP_DEPTH     = 3;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 6;
endpackage

// File: rtl/ram_hs_if.sv
// Handshake bus for ram_hs: byte-masked write port plus a read request /
// read response pair with independent ready signals.
//   master: drives wr_*, rd_req, rd_addr, rd_resp_ready
//   slave : drives rd_req_ready, rd_valid, rd_data
interface ram_hs_if import ram_pkg::*; #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_req_ready;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_resp_ready;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_resp_ready,
    input  rd_req_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr, rd_resp_ready,
    output rd_req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_resp_fifo.sv
// In-order response buffer for ram_hs.
//   clk, rst   : clock, asynchronous active-high reset (clears pointers/count)
//   push       : write push_data into the tail (ignored when full and not popping)
//   pop        : consumer ready; pops the head only when valid
//   valid      : buffer non-empty
//   data       : head entry, zero while empty
//   count      : number of buffered entries
module ram_resp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [WIDTH-1:0]             data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign data    = valid ? slots[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ram_hs.sv
// Word-addressed RAM with a byte-masked write port and a credit-managed read
// port feeding a small response buffer.
//   clk, rst : clock, asynchronous active-high reset (array contents survive)
//   bus      : ram_hs_if slave modport (write port, read request, read response)
// BYPASS=1 returns the merged new word on a same-edge read/write hit,
// BYPASS=0 returns the old word.
module ram_hs import ram_pkg::*; #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input logic     clk,
  input logic     rst,
  ram_hs_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              wr_go;
  logic              accept;
  logic              inflight_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   hit_be_q;
  logic [DATA_W-1:0] merged;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credits_used;

  assign wr_go = bus.wr_en && !rst;

  // Credits count both the read in flight and the buffered responses, so an
  // accepted read always has a buffer slot waiting for it.
  assign credits_used     = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign bus.rd_req_ready = !rst && (credits_used <= (CNT_W+1)'(RESP_DEPTH - 1));
  assign accept           = bus.rd_req && bus.rd_req_ready;

  // Array and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
    if (accept) old_q <= mem[bus.rd_addr];
  end

  // The RAM read returns the old word; a same-address write hit is captured
  // alongside it and merged one cycle later instead of through the array.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q  <= bus.wr_data;
      hit_be_q <= (BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr)) ? bus.wr_be : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= accept;
  end

  always_comb begin
    merged = old_q;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (hit_be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  ram_resp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (merged),
    .pop       (bus.rd_resp_ready),
    .valid     (bus.rd_valid),
    .data      (bus.rd_data),
    .count     (count)
  );
endmodule

// File: tb/tb_ram_hs.sv
// Bench for ram_hs: one BYPASS=1 and one BYPASS=0 instance share identical
// stimulus; a queue/array reference model predicts both every cycle.
module tb_ram_hs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic        rd_resp_ready = 1'b0;

  always #5 clk = ~clk;

  ram_hs_if #(.DATA_W(32), .ADDR_W(6)) bus1 ();
  ram_hs_if #(.DATA_W(32), .ADDR_W(6)) bus0 ();

  assign bus1.wr_en = wr_en;   assign bus0.wr_en = wr_en;
  assign bus1.wr_addr = wr_addr; assign bus0.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data; assign bus0.wr_data = wr_data;
  assign bus1.wr_be = wr_be;   assign bus0.wr_be = wr_be;
  assign bus1.rd_req = rd_req; assign bus0.rd_req = rd_req;
  assign bus1.rd_addr = rd_addr; assign bus0.rd_addr = rd_addr;
  assign bus1.rd_resp_ready = rd_resp_ready;
  assign bus0.rd_resp_ready = rd_resp_ready;

  ram_hs #(.DATA_W(32), .ADDR_W(6), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_hs #(.DATA_W(32), .ADDR_W(6), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Reference model: an outstanding-read queue (each entry becomes visible two
  // cycles after acceptance) and a plain word array.
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    int unsigned rc;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mem_m [64];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] e1, e0;
    v  = !rst && (q.size() > 0) && (q[0].rc <= cyc);
    e1 = v ? q[0].d1 : 32'h0;
    e0 = v ? q[0].d0 : 32'h0;
    check("ready_b1", {31'b0, bus1.rd_req_ready}, {31'b0, !rst && (q.size() <= 2)});
    check("ready_b0", {31'b0, bus0.rd_req_ready}, {31'b0, !rst && (q.size() <= 2)});
    check("valid_b1", {31'b0, bus1.rd_valid}, {31'b0, v});
    check("valid_b0", {31'b0, bus0.rd_valid}, {31'b0, v});
    check("data_b1", bus1.rd_data, e1);
    check("data_b0", bus0.rd_data, e0);
  endtask

  // One clock: update the model with the inputs seen at the edge, then check
  // the DUT outputs at the following falling edge.
  task automatic tick(output bit accepted);
    bit    vis, rdy;
    resp_t e;
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      vis = (q.size() > 0) && (q[0].rc <= cyc);
      rdy = (q.size() <= 2);
      if (vis && rd_resp_ready) void'(q.pop_front());
      if (rd_req && rdy) begin
        e.d0 = mem_m[rd_addr];
        e.d1 = e.d0;
        if (wr_en && wr_addr == rd_addr)
          for (int b = 0; b < 4; b++) if (wr_be[b]) e.d1[8*b +: 8] = wr_data[8*b +: 8];
        e.rc = cyc + 2;
        q.push_back(e);
        accepted = 1'b1;
      end
      if (wr_en)
        for (int b = 0; b < 4; b++) if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic        re;
    logic [5:0]  ra;
    logic        ev;
    logic [31:0] ed1;
    logic [31:0] ed0;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    int unsigned got_cyc[$];
    int unsigned n_acc;

    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;

    // Rows: inputs held for one edge, outputs expected after that edge.
    tbl[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 1'b0, 6'd0,  1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd5,  1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 6'd5,  32'h11223344, 4'h5, 1'b0, 6'd0,  1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd5,  1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'hDE22BE44, 32'hDE22BE44};
    tbl[6]  = '{1'b1, 6'd9,  32'hAAAA5555, 4'hF, 1'b1, 6'd9,  1'b0, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'hAAAA5555, 32'h00000000};
    tbl[8]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd9,  1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'hAAAA5555, 32'hAAAA5555};
    tbl[10] = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'h0, 1'b1, 6'd5,  1'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'hDE22BE44, 32'hDE22BE44};
    tbl[12] = '{1'b1, 6'd20, 32'h12345678, 4'h3, 1'b1, 6'd21, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'h0, 32'h0};
    tbl[14] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 6'd20, 1'b0, 32'h0, 32'h0};
    tbl[15] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 6'd0,  1'b1, 32'h00005678, 32'h00005678};

    // Reset state
    @(negedge clk);
    check_outputs();
    tick(acc);
    tick(acc);
    rst = 1'b0;
    rd_resp_ready = 1'b1;
    tick(acc);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_be = tbl[i].wbe;
      rd_req = tbl[i].re; rd_addr = tbl[i].ra;
      tick(acc);
      check($sformatf("tbl%0d_valid", i), {31'b0, bus1.rd_valid}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_data_b1", i), bus1.rd_data, tbl[i].ed1);
      check($sformatf("tbl%0d_data_b0", i), bus0.rd_data, tbl[i].ed0);
    end
    wr_en = 1'b0; rd_req = 1'b0;

    // Full buffer with a stalled consumer, then drain in order
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = 32'h0BAD0000 + 32'(i) * 32'h1111; wr_be = 4'hF;
      tick(acc);
    end
    wr_en = 1'b0;
    rd_resp_ready = 1'b0; rd_req = 1'b1; rd_addr = 6'd0; n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      if (acc) begin n_acc++; rd_addr = rd_addr + 6'd1; end
    end
    check("stall_accepts", n_acc, 32'd3);
    check("stall_ready", {31'b0, bus1.rd_req_ready}, 32'd0);
    check("stall_head", bus1.rd_data, 32'h0BAD0000);
    rd_resp_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (bus1.rd_valid) got.push_back(bus1.rd_data);
      tick(acc);
      if (acc) begin n_acc++; rd_req = 1'b0; end
    end
    check("drain_accepts", n_acc, 32'd4);
    check("drain_count", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("drain_order%0d", i), got[i], 32'h0BAD0000 + 32'(i) * 32'h1111);

    // Back-to-back reads with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = {16'hA5A5, 8'(i), ~8'(i)}; wr_be = 4'hF;
      tick(acc);
    end
    wr_en = 1'b0; rd_req = 1'b1;
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        rd_addr = 6'(i);
        check($sformatf("b2b_ready%0d", i), {31'b0, bus1.rd_req_ready}, 32'd1);
      end else begin
        rd_req = 1'b0;
      end
      if (bus1.rd_valid) begin got.push_back(bus1.rd_data); got_cyc.push_back(cyc); end
      tick(acc);
    end
    check("b2b_count", got.size(), 32'd16);
    if (got.size() == 16) begin
      check("b2b_span", got_cyc[15] - got_cyc[0], 32'd15);
      for (int i = 0; i < 16; i++)
        check($sformatf("b2b_data%0d", i), got[i], {16'hA5A5, 8'(i), ~8'(i)});
    end

    // Reset with two buffered responses and one in flight
    rd_resp_ready = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin rd_addr = 6'(i); tick(acc); end
    rd_req = 1'b0;
    check("pre_rst_valid", {31'b0, bus1.rd_valid}, 32'd1);
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_valid", {31'b0, bus1.rd_valid}, 32'd0);
    check("rst_data", bus1.rd_data, 32'd0);
    check("rst_ready", {31'b0, bus1.rd_req_ready}, 32'd0);
    wr_en = 1'b1; wr_addr = 6'd20; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_req = 1'b1; rd_addr = 6'd20;
    tick(acc);
    tick(acc);
    rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0; rd_resp_ready = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, bus1.rd_req_ready}, 32'd1);
    check("post_rst_valid", {31'b0, bus1.rd_valid}, 32'd0);
    for (int i = 0; i < 4; i++) tick(acc);
    rd_req = 1'b1; rd_addr = 6'd20;
    tick(acc);
    rd_req = 1'b0;
    tick(acc);
    check("post_rst_data", bus1.rd_data, 32'h00005678);
    check("post_rst_data_valid", {31'b0, bus1.rd_valid}, 32'd1);
    tick(acc);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) q.delete();
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 6'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be = 4'($urandom_range(0, 15));
      rd_req = $urandom_range(0, 2) != 0;
      rd_addr = 6'($urandom_range(0, 7));
      rd_resp_ready = $urandom_range(0, 1) == 1;
      tick(acc);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
